// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO that captures each completed UART byte plus its error bit.
// One-cycle push latency, combinational head read; when full a new byte is dropped and overrun_flag is set sticky.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_received,
  input  logic              data_corrupted_flag,
  input  logic              transmission_done_flag,
  input  logic              rd_en,
  input  logic              overrun_clr,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun_flag
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              done_d;
  logic              push;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    push    = transmission_done_flag & ~done_d;
    do_pop  = rd_en & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    rd_data = mem[rp][7:0];
    rd_err  = mem[rp][8];
  end

  // done_d resets high so a flag already asserted at reset release is not captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_d       <= 1'b1;
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      overrun_flag <= 1'b0;
    end else begin
      done_d <= transmission_done_flag;
      if (do_push)
        wp <= wp + ADDR_W'(1);
      if (do_pop)
        rp <= rp + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (drop)
        overrun_flag <= 1'b1;
      else if (overrun_clr)
        overrun_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem[wp] <= {data_corrupted_flag, data_received};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized checks of uart_rx_fifo against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        data_received = 8'h00;
  logic              data_corrupted_flag = 1'b0;
  logic              transmission_done_flag = 1'b1;
  logic              rd_en = 1'b0;
  logic              overrun_clr = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_err;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun_flag;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  bit         m_prev = 1'b1;
  bit         m_ovr  = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .data_received(data_received),
    .data_corrupted_flag(data_corrupted_flag),
    .transmission_done_flag(transmission_done_flag),
    .rd_en(rd_en), .overrun_clr(overrun_clr),
    .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .count(count),
    .overrun_flag(overrun_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare outputs.
  task automatic cyc();
    bit rise;
    bit dropped;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b1;
    end else begin
      rise    = transmission_done_flag && !m_prev;
      m_prev  = transmission_done_flag;
      dropped = 1'b0;
      if (rd_en && q.size() != 0)
        void'(q.pop_front());
      if (rise) begin
        if (q.size() < DEPTH) q.push_back({data_corrupted_flag, data_received});
        else dropped = 1'b1;
      end
      if (dropped) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overrun", 32'(overrun_flag), 32'(m_ovr));
    if (q.size() != 0) begin
      chk("rd_data", 32'(rd_data), 32'(q[0][7:0]));
      chk("rd_err", 32'(rd_err), 32'(q[0][8]));
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e, input logic rd, input logic clr);
    data_received = d;
    data_corrupted_flag = e;
    transmission_done_flag = 1'b1;
    rd_en = rd;
    overrun_clr = clr;
    cyc();
    transmission_done_flag = 1'b0;
    rd_en = 1'b0;
    overrun_clr = 1'b0;
    cyc();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset with the done flag held high, then release with it still high.
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("no_capture_count", 32'(count), 32'd0);
    chk("no_capture_empty", 32'(empty), 32'd1);
    transmission_done_flag = 1'b0;
    cyc();

    // Single byte, flag held four cycles.
    data_received = 8'hA5;
    data_corrupted_flag = 1'b0;
    transmission_done_flag = 1'b1;
    repeat (4) cyc();
    transmission_done_flag = 1'b0;
    cyc();
    chk("single_count", 32'(count), 32'd1);
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_err", 32'(rd_err), 32'd0);
    pop_one();
    chk("single_popped", 32'(empty), 32'd1);

    // Fill, partial drain, refill across the wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    for (int i = 0; i < 8; i++) pop_one();
    for (int i = 16; i < 24; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 8; i < 24; i++) begin
      chk("wrap_order", 32'(rd_data), 32'(i));
      pop_one();
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Overrun: dropped byte, set beats clear, clear alone.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    push_byte(8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_flag", 32'(overrun_flag), 32'd1);
    chk("ovr_head", 32'(rd_data), 32'h40);
    push_byte(8'hEF, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(overrun_flag), 32'd1);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun_flag), 32'd0);

    // Full with simultaneous pop: no drop, new byte goes last.
    push_byte(8'h55, 1'b0, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_ovr", 32'(overrun_flag), 32'd0);
    for (int i = 0; i < 15; i++) pop_one();
    chk("fullpp_last", 32'(rd_data), 32'h55);
    pop_one();
    chk("fullpp_empty", 32'(empty), 32'd1);

    // Empty with rd_en during push: pop ignored.
    push_byte(8'h33, 1'b0, 1'b1, 1'b0);
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_data", 32'(rd_data), 32'h33);
    pop_one();

    // Corrupted byte is queued and tagged.
    push_byte(8'h7E, 1'b1, 1'b0, 1'b0);
    chk("err_data", 32'(rd_data), 32'h7E);
    chk("err_bit", 32'(rd_err), 32'd1);

    // Reset with five entries queued.
    for (int i = 0; i < 4; i++) push_byte(8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) transmission_done_flag = ~transmission_done_flag;
      data_received = 8'($urandom);
      data_corrupted_flag = ($urandom_range(0, 3) == 0);
      rd_en = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 2 : 7));
      overrun_clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
